fgp_rx_framed: RTL and testbench
================================

Name: fgp_rx_framed

Overview:
- Parametrised FGP packet parser for the receive path. Sits between the Ethernet payload stream and the framebuffer write port.
- Accepts a byte stream with an explicit end-of-frame marker. Parses a multi-byte big-endian offset, skips or checks the padding, and forwards the data bytes with their index.
- Detects short frames, non-zero padding and out-of-range offsets. Re-synchronises on the next frame after any error.
- All outputs are registered.

Parameters:
- OFFSET_LEN, 1, offset field length in bytes, big-endian, range 1..3.
- PADDING_LEN, 127, padding bytes following the offset, must be at least 1.
- DATA_LEN, 768, data bytes per packet, must be at least 2.
- OFFSET_SHIFT, 9, left shift applied to the offset to form setoff_val (colours per packet = 2^OFFSET_SHIFT).
- MAX_OFFSET, 2**(8*OFFSET_LEN), offsets greater than or equal to this are rejected.
- CHECK_PADDING, 1, when 1 any non-zero padding byte is an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- inclk  in  1  byte strobe; in and in_last are valid when inclk=1.
- in  in  8  payload byte.
- in_last  in  1  qualified by inclk; marks the final byte of the Ethernet payload.
- outclk  out  1  strobe for a data byte.
- out  out  8  data byte.
- out_idx  out  clog2(DATA_LEN)  index of the data byte within the packet, 0..DATA_LEN-1.
- setoff_req  out  1  one-cycle pulse: a new offset is valid.
- setoff_val  out  8*OFFSET_LEN+OFFSET_SHIFT  offset concatenated with OFFSET_SHIFT zero bits.
- done  out  1  one-cycle pulse: the last data byte was delivered.
- err  out  1  one-cycle pulse: the packet was rejected.
- err_code  out  2  cause of the error: 1=SHORT, 2=PAD, 3=RANGE; holds its value until the next err pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=OFFSET, counter=0, offset accumulator=0.
  - All outputs 0, including err_code.
  - Reset mid-frame discards the partial frame. The next accepted byte is treated as offset byte 0.
- Latency: every output is registered and appears 1 cycle after the inclk cycle that produced it. When inclk=0, the internal state does not change and all strobe and pulse outputs are 0 on the following cycle.
- State OFFSET:
  - Each byte shifts into the accumulator, most significant byte first.
  - On byte OFFSET_LEN-1, form the full offset value (accumulator plus this byte), then:
    - if the value is less than MAX_OFFSET: pulse setoff_req with setoff_val = {offset, zeros}, go to PADDING, counter=0;
    - otherwise: pulse err with code RANGE, no setoff_req, go to DRAIN.
- State PADDING:
  - Bytes are counted and discarded.
  - If CHECK_PADDING=1 and a byte is non-zero: pulse err with code PAD, go to DRAIN.
  - On byte PADDING_LEN-1 with no error: go to DATA, counter=0.
- State DATA:
  - Each byte gives outclk=1, out=byte, out_idx=counter.
  - On byte DATA_LEN-1: pulse done on the same cycle as that byte's outclk.
    - If in_last is set on that byte, go to OFFSET.
    - Otherwise go to DRAIN, which ignores trailing bytes such as Ethernet padding without an error.
- State DRAIN:
  - Bytes are discarded, no outputs.
  - in_last returns the block to OFFSET.
- Short frame:
  - in_last on any byte in OFFSET, PADDING, or DATA before index DATA_LEN-1 ends the frame early.
  - Response: pulse err with code SHORT, go to OFFSET.
  - The byte carrying in_last is still processed first (a data byte is still forwarded on outclk).
  - done is never pulsed for that frame.
- Simultaneous conditions on one byte: RANGE or PAD takes priority over SHORT. When in_last coincides with RANGE or PAD, go straight to OFFSET rather than DRAIN. At most one err pulse per frame.
- setoff_val holds its value until the next setoff_req.
- out and out_idx hold their values when outclk=0.
- The counter is wide enough for max(PADDING_LEN, DATA_LEN) and never wraps within a state.

Test Plan:
- Default parameters; frame of offset 0x05, 127 zero bytes, data bytes i%256, in_last on the final data byte:
  - setoff_req pulses once with setoff_val=0x0A00;
  - 768 outclk strobes with out_idx 0..767 and matching data;
  - done pulses with out_idx=767; err stays 0.
- Same frame followed by 10 trailing bytes, in_last on the last of them:
  - done pulses at data byte 767; trailing bytes produce no outclk and no err;
  - a second back-to-back frame parses correctly.
- Padding byte 40 = 0x01, CHECK_PADDING=1:
  - err with err_code=2; no outclk for the frame;
  - the next frame with offset 0x07 gives setoff_val=0x0E00.
- MAX_OFFSET=200, offset byte 0xC8:
  - err with err_code=3; no setoff_req;
  - following bytes ignored until in_last.
- in_last on data byte 99:
  - 100 outclk strobes, then err with err_code=1; no done;
  - the next byte is parsed as an offset.
- OFFSET_LEN=2, offset bytes 0x01 0x2C:
  - setoff_val=0x25800;
  - a reset pulse mid-DATA clears all outputs asynchronously and the following frame parses cleanly.

Source files
------------

// File: rtl/fgp_rx_framed.sv
// ---------------------------------------------------------------------------
// fgp_rx_framed
//   FGP packet parser for the receive path. Consumes the Ethernet payload as a
//   byte stream with an explicit end-of-frame marker, extracts a big-endian
//   offset, checks or skips the padding and forwards the data bytes together
//   with their index inside the packet. Short frames, non-zero padding and
//   out-of-range offsets are reported and the parser re-synchronises on the
//   next frame.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   inclk       byte strobe; in / in_last are valid while inclk=1
//   in          payload byte
//   in_last     marks the final byte of the Ethernet payload
//   outclk      strobe for a forwarded data byte
//   out         forwarded data byte (holds while outclk=0)
//   out_idx     index of the data byte, 0..DATA_LEN-1 (holds while outclk=0)
//   setoff_req  one-cycle pulse: setoff_val carries a new offset
//   setoff_val  offset followed by OFFSET_SHIFT zero bits (holds)
//   done        one-cycle pulse together with the last data byte
//   err         one-cycle pulse: the packet was rejected
//   err_code    1=SHORT, 2=PAD, 3=RANGE; holds until the next err pulse
//
// All outputs are registered and follow the accepted byte by one cycle.
// ---------------------------------------------------------------------------
module fgp_rx_framed #(
  parameter int OFFSET_LEN    = 1,
  parameter int PADDING_LEN   = 127,
  parameter int DATA_LEN      = 768,
  parameter int OFFSET_SHIFT  = 9,
  parameter int MAX_OFFSET    = 2**(8*OFFSET_LEN),
  parameter int CHECK_PADDING = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inclk,
  input  logic [7:0]                           in,
  input  logic                                 in_last,
  output logic                                 outclk,
  output logic [7:0]                           out,
  output logic [$clog2(DATA_LEN)-1:0]          out_idx,
  output logic                                 setoff_req,
  output logic [8*OFFSET_LEN+OFFSET_SHIFT-1:0] setoff_val,
  output logic                                 done,
  output logic                                 err,
  output logic [1:0]                           err_code
);

  localparam int OFF_W   = 8 * OFFSET_LEN;
  localparam int VAL_W   = OFF_W + OFFSET_SHIFT;
  localparam int IDX_W   = $clog2(DATA_LEN);
  // The counter also indexes the offset bytes, so it must reach at least 3.
  localparam int CNT_MAX = (PADDING_LEN > DATA_LEN) ?
                           ((PADDING_LEN > 4) ? PADDING_LEN : 4) :
                           ((DATA_LEN > 4) ? DATA_LEN : 4);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFFSET_LEN - 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PADDING_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [32:0]      MAX_OFF   = 33'(MAX_OFFSET);

  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_PAD   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [1:0] {
    S_OFFSET  = 2'd0,
    S_PADDING = 2'd1,
    S_DATA    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OFF_W-1:0]   acc_q, acc_d;
  logic               outclk_q, outclk_d;
  logic [7:0]         out_q, out_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               setoff_req_q, setoff_req_d;
  logic [VAL_W-1:0]   setoff_val_q, setoff_val_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [OFF_W-1:0]   off_full_s;
  logic               off_ok_s;

  // Offset value including the byte currently on the input.
  assign off_full_s = (acc_q << 8) | OFF_W'(in);
  assign off_ok_s   = (33'(off_full_s) < MAX_OFF);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    outclk_d     = 1'b0;
    out_d        = out_q;
    out_idx_d    = out_idx_q;
    setoff_req_d = 1'b0;
    setoff_val_d = setoff_val_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    if (inclk) begin
      case (state_q)
        S_OFFSET: begin
          acc_d = off_full_s;
          if (cnt_q == OFF_LAST) begin
            acc_d = '0;
            cnt_d = '0;
            if (off_ok_s) begin
              setoff_req_d = 1'b1;
              setoff_val_d = VAL_W'(off_full_s) << OFFSET_SHIFT;
              if (in_last) begin
                err_d      = 1'b1;
                err_code_d = ERR_SHORT;
                state_d    = S_OFFSET;
              end else begin
                state_d    = S_PADDING;
              end
            end else begin
              // RANGE wins over SHORT; an in_last here already ends the frame.
              err_d      = 1'b1;
              err_code_d = ERR_RANGE;
              state_d    = in_last ? S_OFFSET : S_DRAIN;
            end
          end else if (in_last) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_OFFSET;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_PADDING: begin
          if ((CHECK_PADDING != 0) && (in != 8'h00)) begin
            err_d      = 1'b1;
            err_code_d = ERR_PAD;
            cnt_d      = '0;
            state_d    = in_last ? S_OFFSET : S_DRAIN;
          end else if (in_last) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
            cnt_d      = '0;
            state_d    = S_OFFSET;
          end else if (cnt_q == PAD_LAST) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          outclk_d  = 1'b1;
          out_d     = in;
          out_idx_d = cnt_q[IDX_W-1:0];
          if (cnt_q == DATA_LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            // Without in_last the frame carries trailing bytes to swallow.
            state_d = in_last ? S_OFFSET : S_DRAIN;
          end else if (in_last) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
            cnt_d      = '0;
            state_d    = S_OFFSET;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          if (in_last) begin
            state_d = S_OFFSET;
          end else begin
            state_d = S_DRAIN;
          end
        end

        default: begin
          state_d = S_OFFSET;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_OFFSET;
      cnt_q        <= '0;
      acc_q        <= '0;
      outclk_q     <= 1'b0;
      out_q        <= 8'h00;
      out_idx_q    <= '0;
      setoff_req_q <= 1'b0;
      setoff_val_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      outclk_q     <= outclk_d;
      out_q        <= out_d;
      out_idx_q    <= out_idx_d;
      setoff_req_q <= setoff_req_d;
      setoff_val_q <= setoff_val_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign outclk     = outclk_q;
  assign out        = out_q;
  assign out_idx    = out_idx_q;
  assign setoff_req = setoff_req_q;
  assign setoff_val = setoff_val_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_fgp_rx_framed.sv
// Bench for fgp_rx_framed: three instances (default, MAX_OFFSET=200,
// OFFSET_LEN=2) share the byte bus; only one gets inclk at a time. Expected
// events are queued with the stimulus and a negedge monitor pops and compares.
module tb_fgp_rx_framed;

  localparam int K_DATA = 0;
  localparam int K_SET  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] v0;
    logic [31:0] v1;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inclk_a, inclk_b, inclk_c;
  logic [7:0] din;
  logic       dlast;

  logic        outclk_a, setoff_req_a, done_a, err_a;
  logic [7:0]  out_a;
  logic [9:0]  out_idx_a;
  logic [16:0] setoff_val_a;
  logic [1:0]  err_code_a;

  logic        outclk_b, setoff_req_b, done_b, err_b;
  logic [7:0]  out_b;
  logic [9:0]  out_idx_b;
  logic [16:0] setoff_val_b;
  logic [1:0]  err_code_b;

  logic        outclk_c, setoff_req_c, done_c, err_c;
  logic [7:0]  out_c;
  logic [9:0]  out_idx_c;
  logic [24:0] setoff_val_c;
  logic [1:0]  err_code_c;

  always #5 clk = ~clk;

  fgp_rx_framed u_a (
    .clk(clk), .rst(rst_n), .inclk(inclk_a), .in(din), .in_last(dlast),
    .outclk(outclk_a), .out(out_a), .out_idx(out_idx_a),
    .setoff_req(setoff_req_a), .setoff_val(setoff_val_a),
    .done(done_a), .err(err_a), .err_code(err_code_a)
  );

  fgp_rx_framed #(.MAX_OFFSET(200)) u_b (
    .clk(clk), .rst(rst_n), .inclk(inclk_b), .in(din), .in_last(dlast),
    .outclk(outclk_b), .out(out_b), .out_idx(out_idx_b),
    .setoff_req(setoff_req_b), .setoff_val(setoff_val_b),
    .done(done_b), .err(err_b), .err_code(err_code_b)
  );

  fgp_rx_framed #(.OFFSET_LEN(2)) u_c (
    .clk(clk), .rst(rst_n), .inclk(inclk_c), .in(din), .in_last(dlast),
    .outclk(outclk_c), .out(out_c), .out_idx(out_idx_c),
    .setoff_req(setoff_req_c), .setoff_val(setoff_val_c),
    .done(done_c), .err(err_c), .err_code(err_code_c)
  );

  // ---------------- scoreboard ----------------
  task automatic expect_ev(input int d, input int k, input logic [31:0] v0, input logic [31:0] v1);
    ev_t e;
    e.dut = d; e.kind = k; e.v0 = v0; e.v1 = v1;
    exp_q.push_back(e);
  endtask

  task automatic match(input int d, input int k, input logic [31:0] v0, input logic [31:0] v1,
                       input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s dut%0d: got kind=%0d v0=0x%0h v1=%0d, required no event", name, d, k, v0, v1);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || e.v0 != v0 || e.v1 != v1) begin
        n_errors++;
        $display("FAIL %s dut%0d: got kind=%0d v0=0x%0h v1=%0d, required dut%0d kind=%0d v0=0x%0h v1=%0d",
                 name, d, k, v0, v1, e.dut, e.kind, e.v0, e.v1);
      end
    end
  endtask

  task automatic observe(input int d, input logic oc, input logic [7:0] ob, input logic [31:0] oi,
                         input logic sr, input logic [31:0] sv, input logic dn,
                         input logic er, input logic [1:0] ec);
    if (oc) match(d, K_DATA, 32'(ob), oi, "data");
    if (sr) match(d, K_SET, sv, 32'd0, "setoff");
    if (dn) match(d, K_DONE, oi, 32'd0, "done");
    if (er) match(d, K_ERR, 32'(ec), 32'd0, "err");
  endtask

  always @(negedge clk) begin
    observe(0, outclk_a, out_a, 32'(out_idx_a), setoff_req_a, 32'(setoff_val_a), done_a, err_a, err_code_a);
    observe(1, outclk_b, out_b, 32'(out_idx_b), setoff_req_b, 32'(setoff_val_b), done_b, err_b, err_code_b);
    observe(2, outclk_c, out_c, 32'(out_idx_c), setoff_req_c, 32'(setoff_val_c), done_c, err_c, err_code_c);
  end

  task automatic chk_eq(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  task automatic chk_zero(input int d, input logic oc, input logic [7:0] ob, input logic [9:0] oi,
                          input logic sr, input logic [24:0] sv, input logic dn,
                          input logic er, input logic [1:0] ec);
    chk_eq($sformatf("rst_outclk_%0d", d), 32'(oc), 32'd0);
    chk_eq($sformatf("rst_out_%0d", d), 32'(ob), 32'd0);
    chk_eq($sformatf("rst_out_idx_%0d", d), 32'(oi), 32'd0);
    chk_eq($sformatf("rst_setoff_req_%0d", d), 32'(sr), 32'd0);
    chk_eq($sformatf("rst_setoff_val_%0d", d), 32'(sv), 32'd0);
    chk_eq($sformatf("rst_done_%0d", d), 32'(dn), 32'd0);
    chk_eq($sformatf("rst_err_%0d", d), 32'(er), 32'd0);
    chk_eq($sformatf("rst_err_code_%0d", d), 32'(ec), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [7:0] b, input logic last);
    @(negedge clk);
    din     = b;
    dlast   = last;
    inclk_a = (d == 0);
    inclk_b = (d == 1);
    inclk_c = (d == 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      inclk_a = 1'b0; inclk_b = 1'b0; inclk_c = 1'b0;
      din = 8'h00; dlast = 1'b0;
    end
  endtask

  task automatic send_offset(input int d, input int olen, input logic [23:0] off, input logic last_final);
    logic [23:0] o;
    o = off;
    for (int i = olen - 1; i >= 0; i--) send(d, o[8*i +: 8], last_final && (i == 0));
  endtask

  task automatic send_pad(input int d, input int n, input logic last_final);
    for (int i = 0; i < n; i++) send(d, 8'h00, last_final && (i == n - 1));
  endtask

  task automatic send_data(input int d, input int n, input int mul, input logic last_final, input logic do_exp);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'(i * mul + d);
      if (do_exp) expect_ev(d, K_DATA, 32'(v), 32'(i));
      send(d, v, last_final && (i == n - 1));
    end
  endtask

  task automatic good_frame(input int d, input int olen, input logic [23:0] off,
                            input logic [31:0] setoff_exp, input int mul, input int trail);
    expect_ev(d, K_SET, setoff_exp, 32'd0);
    send_offset(d, olen, off, 1'b0);
    send_pad(d, 127, 1'b0);
    send_data(d, 768, mul, (trail == 0), 1'b1);
    expect_ev(d, K_DONE, 32'd767, 32'd0);
    for (int t = 0; t < trail; t++) send(d, 8'hA5, (t == trail - 1));
  endtask

  initial begin
    rst_n = 1'b0;
    inclk_a = 1'b0; inclk_b = 1'b0; inclk_c = 1'b0;
    din = 8'h00; dlast = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk_zero(0, outclk_a, out_a, out_idx_a, setoff_req_a, 25'(setoff_val_a), done_a, err_a, err_code_a);
    chk_zero(1, outclk_b, out_b, out_idx_b, setoff_req_b, 25'(setoff_val_b), done_b, err_b, err_code_b);

    // Default instance: clean frame, then a frame with trailing bytes and a back-to-back one.
    good_frame(0, 1, 24'h05, 32'h0A00, 1, 0);
    good_frame(0, 1, 24'h05, 32'h0A00, 1, 10);
    good_frame(0, 1, 24'h09, 32'h1200, 3, 0);

    // Non-zero padding byte 40: PAD error, rest of frame is drained silently.
    expect_ev(0, K_SET, 32'h0600, 32'd0);
    send_offset(0, 1, 24'h03, 1'b0);
    send_pad(0, 40, 1'b0);
    send(0, 8'h01, 1'b0);
    expect_ev(0, K_ERR, 32'd2, 32'd0);
    send_pad(0, 86, 1'b0);
    send_data(0, 768, 1, 1'b1, 1'b0);
    good_frame(0, 1, 24'h07, 32'h0E00, 5, 0);
    idle(2);
    chk_eq("err_code_hold", 32'(err_code_a), 32'd2);

    // Short in data at byte 99, then short on the last padding byte.
    expect_ev(0, K_SET, 32'h0400, 32'd0);
    send_offset(0, 1, 24'h02, 1'b0);
    send_pad(0, 127, 1'b0);
    send_data(0, 100, 1, 1'b1, 1'b1);
    expect_ev(0, K_ERR, 32'd1, 32'd0);
    expect_ev(0, K_SET, 32'h0800, 32'd0);
    send_offset(0, 1, 24'h04, 1'b0);
    send_pad(0, 127, 1'b1);
    expect_ev(0, K_ERR, 32'd1, 32'd0);
    good_frame(0, 1, 24'h06, 32'h0C00, 1, 0);

    // MAX_OFFSET=200: offset 200 rejected, 199 accepted; RANGE with in_last.
    send(1, 8'hC8, 1'b0);
    expect_ev(1, K_ERR, 32'd3, 32'd0);
    for (int i = 0; i < 20; i++) send(1, 8'h00, (i == 19));
    good_frame(1, 1, 24'hC7, 32'h18E00, 1, 0);
    send(1, 8'hFF, 1'b1);
    expect_ev(1, K_ERR, 32'd3, 32'd0);
    good_frame(1, 1, 24'h01, 32'h0200, 2, 0);
    idle(2);
    chk_eq("err_code_hold_b", 32'(err_code_b), 32'd3);

    // OFFSET_LEN=2: short inside the offset, then 0x012C and a reset mid-DATA.
    send(2, 8'h01, 1'b1);
    expect_ev(2, K_ERR, 32'd1, 32'd0);
    expect_ev(2, K_SET, 32'h25800, 32'd0);
    send_offset(2, 2, 24'h012C, 1'b0);
    send_pad(2, 127, 1'b0);
    send_data(2, 50, 1, 1'b0, 1'b1);
    idle(1);
    chk_eq("pre_rst_outclk_c", 32'(outclk_c), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero(2, outclk_c, out_c, out_idx_c, setoff_req_c, setoff_val_c, done_c, err_c, err_code_c);
    #1 rst_n = 1'b1;
    good_frame(2, 2, 24'h012C, 32'h25800, 7, 0);

    idle(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_events: got %0d unseen events, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
